// File: rtl/frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_streamer_if
// Description : Upstream valid/ready pixel channel with start-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_streamer_if #(
    parameter int VALUE_BITS = 9
);
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_sof;
    logic [VALUE_BITS-1:0] s_data;

    modport master (output s_valid, output s_sof, output s_data, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_streamer
// Description : Frame source for the kernel pipeline: frames pixels, flags
//               SOF/EOL, drains with zero beats and qualifies centred results.
//               Optional SOF_RESYNC_EN: an SOF seen mid-frame restarts it.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_streamer #(
    parameter int FRAME_WIDTH   = 1024,
    parameter int FRAME_HEIGHT  = 768,
    parameter int VALUE_BITS    = 9,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int PIPE_STAGES   = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    frame_streamer_if.slave            up,
    output logic                       en,
    output logic [VALUE_BITS-1:0]      value_out,
    output logic                       sof_out,
    output logic                       eol_out,
    output logic                       out_valid,
    output logic                       frame_done
);

    localparam int DRAIN_BEATS = FRAME_WIDTH * (KERNEL_HEIGHT / 2) + KERNEL_WIDTH / 2 + PIPE_STAGES;
    localparam int TOTAL_BEATS = FRAME_WIDTH * FRAME_HEIGHT + DRAIN_BEATS;
    localparam int X_W = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int Y_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int B_W = (TOTAL_BEATS  > 1) ? $clog2(TOTAL_BEATS)  : 1;
    localparam int D_W = (DRAIN_BEATS  > 1) ? $clog2(DRAIN_BEATS)  : 1;

    localparam logic [X_W-1:0] X_LAST     = X_W'(FRAME_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(FRAME_HEIGHT - 1);
    localparam logic [B_W-1:0] B_VALID    = B_W'(DRAIN_BEATS);
    localparam logic [D_W-1:0] DRAIN_LOAD = D_W'(DRAIN_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;
    logic [B_W-1:0]  r_b;
    logic [D_W-1:0]  r_drain_cnt;
    logic            r_done_pend;

    logic            w_accept;
    logic            w_restart;
    logic            w_pix;
    logic [X_W-1:0]  w_px;
    logic [Y_W-1:0]  w_py;
    logic [B_W-1:0]  w_pb;
    logic            w_eol;
    logic            w_last;

    // Readiness depends only on state so upstream can never form a loop through it.
    assign up.s_ready = rst_n & (r_state != ST_DRAIN);

    always_comb begin
        w_accept  = up.s_valid & up.s_ready;
        w_restart = 1'b0;
        w_pix     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_restart = w_accept & up.s_sof;
                w_pix     = w_restart;
            end
            ST_STREAM: begin
`ifdef SOF_RESYNC_EN
                w_restart = w_accept & up.s_sof;
`else
                w_restart = 1'b0;
`endif
                w_pix     = w_accept;
            end
            default: begin
                w_restart = 1'b0;
                w_pix     = 1'b0;
            end
        endcase
        w_px   = w_restart ? '0 : r_x;
        w_py   = w_restart ? '0 : r_y;
        w_pb   = w_restart ? '0 : r_b;
        w_eol  = (w_px == X_LAST);
        w_last = w_eol && (w_py == Y_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_b         <= '0;
            r_drain_cnt <= '0;
            r_done_pend <= 1'b0;
            en          <= 1'b0;
            value_out   <= '0;
            sof_out     <= 1'b0;
            eol_out     <= 1'b0;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            en          <= 1'b0;
            value_out   <= '0;
            sof_out     <= 1'b0;
            eol_out     <= 1'b0;
            out_valid   <= 1'b0;
            frame_done  <= r_done_pend;
            r_done_pend <= 1'b0;

            if (w_pix) begin
                en        <= 1'b1;
                value_out <= up.s_data;
                sof_out   <= w_restart;
                eol_out   <= w_eol;
                out_valid <= (w_pb >= B_VALID);
                r_b       <= w_pb + B_W'(1);
                if (w_last) begin
                    r_state     <= ST_DRAIN;
                    r_drain_cnt <= DRAIN_LOAD;
                    r_x         <= '0;
                    r_y         <= '0;
                end else begin
                    r_state <= ST_STREAM;
                    if (w_eol) begin
                        r_x <= '0;
                        r_y <= w_py + Y_W'(1);
                    end else begin
                        r_x <= w_px + X_W'(1);
                        r_y <= w_py;
                    end
                end
            end else if (r_state == ST_DRAIN) begin
                // Zero beats push the last real pixels through to the kernel centre.
                en        <= 1'b1;
                out_valid <= (r_b >= B_VALID);
                if (r_drain_cnt == '0) begin
                    r_state     <= ST_IDLE;
                    r_b         <= '0;
                    r_done_pend <= 1'b1;
                end else begin
                    r_drain_cnt <= r_drain_cnt - D_W'(1);
                    r_b         <= r_b + B_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_streamer
// Description : Directed bench for frame_streamer with W=4, H=3, 3x3 kernel,
//               one pipe stage (six drain beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;

    localparam int W       = 4;
    localparam int H       = 3;
    localparam int VB      = 9;
    localparam int N_PIX   = W * H;
    localparam int N_DRAIN = 6;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en;
    logic [VB-1:0] value_out;
    logic          sof_out;
    logic          eol_out;
    logic          out_valid;
    logic          frame_done;

    frame_streamer_if #(.VALUE_BITS(VB)) up_if ();

    frame_streamer #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .VALUE_BITS    (VB),
        .KERNEL_WIDTH  (3),
        .KERNEL_HEIGHT (3),
        .PIPE_STAGES   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (up_if.slave),
        .en         (en),
        .value_out  (value_out),
        .sof_out    (sof_out),
        .eol_out    (eol_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          s;
        logic [VB-1:0] d;
        logic          rdy;
        logic          e;
        logic [VB-1:0] val;
        logic          so;
        logic          eo;
        logic          ov;
        logic          dn;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic v, logic s, logic [VB-1:0] d, logic rdy, logic e,
                                logic [VB-1:0] val, logic so, logic eo, logic ov, logic dn);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.rdy = rdy; t.e = e;
        t.val = val; t.so = so; t.eo = eo; t.ov = ov; t.dn = dn;
        return t;
    endfunction

    // Pixel with frame index i: EOL on column W-1, centred once i reaches the drain depth.
    function automatic vec_t pix_v(int i, logic [VB-1:0] d, logic s);
        return mk(1'b1, s, d, 1'b1, 1'b1, d, i == 0, (i % W) == W - 1, i >= N_DRAIN, 1'b0);
    endfunction

    function automatic vec_t gap_v();
        return mk(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t drain_v(logic v, logic s, logic [VB-1:0] d);
        return mk(v, s, d, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic vec_t done_v();
        return mk(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic void add_frame(bit gaps);
        for (int i = 0; i < N_PIX; i++) begin
            tbl.push_back(pix_v(i, VB'(i + 1), i == 0));
            if (gaps && i < N_PIX - 1) tbl.push_back(gap_v());
        end
        for (int k = 0; k < N_DRAIN; k++) tbl.push_back(drain_v(1'b0, 1'b0, '0));
        tbl.push_back(done_v());
    endfunction

    task automatic check1(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkv(string name, logic [VB-1:0] act, logic [VB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input string tag);
        up_if.s_valid = t.v;
        up_if.s_sof   = t.s;
        up_if.s_data  = t.d;
        #1;
        check1({tag, ".s_ready"}, up_if.s_ready, t.rdy);
        @(posedge clk);
        #2;
        check1({tag, ".en"}, en, t.e);
        check1({tag, ".frame_done"}, frame_done, t.dn);
        if (t.e) begin
            checkv({tag, ".value_out"}, value_out, t.val);
            check1({tag, ".sof_out"}, sof_out, t.so);
            check1({tag, ".eol_out"}, eol_out, t.eo);
            check1({tag, ".out_valid"}, out_valid, t.ov);
        end
    endtask

    task automatic run_frame(string tag);
        for (int i = 0; i < N_PIX; i++)
            step(pix_v(i, VB'(i + 1), i == 0), $sformatf("%s.pix%0d", tag, i));
        for (int k = 0; k < N_DRAIN; k++)
            step(drain_v(1'b0, 1'b0, '0), $sformatf("%s.drain%0d", tag, k));
        step(done_v(), {tag, ".done"});
    endtask

    task automatic check_all_zero(string tag);
        check1({tag, ".en"}, en, 1'b0);
        checkv({tag, ".value_out"}, value_out, '0);
        check1({tag, ".sof_out"}, sof_out, 1'b0);
        check1({tag, ".eol_out"}, eol_out, 1'b0);
        check1({tag, ".out_valid"}, out_valid, 1'b0);
        check1({tag, ".frame_done"}, frame_done, 1'b0);
        check1({tag, ".s_ready"}, up_if.s_ready, 1'b0);
    endtask

    initial begin
        vec_t t;
        up_if.s_valid = 1'b0;
        up_if.s_sof   = 1'b0;
        up_if.s_data  = '0;

        // Table: continuous frame, toggling-valid frame, IDLE junk then a frame.
        add_frame(1'b0);
        add_frame(1'b1);
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(1'b1, 1'b0, VB'(100 + j), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_frame(1'b0);

        #3;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < tbl.size(); n++)
            step(tbl[n], $sformatf("tbl%0d", n));

        // SOF held by upstream through the drain, taken on the first IDLE cycle.
        for (int i = 0; i < N_PIX; i++)
            step(pix_v(i, VB'(i + 1), i == 0), $sformatf("hold.pix%0d", i));
        for (int k = 0; k < N_DRAIN; k++)
            step(drain_v(1'b1, 1'b1, VB'(9'h55)), $sformatf("hold.drain%0d", k));
        t    = pix_v(0, VB'(9'h55), 1'b1);
        t.dn = 1'b1;
        step(t, "hold.accept");
        for (int i = 1; i < N_PIX; i++)
            step(pix_v(i, VB'(i + 1), 1'b0), $sformatf("hold.pix%0d", i));
        for (int k = 0; k < N_DRAIN; k++)
            step(drain_v(1'b0, 1'b0, '0), $sformatf("hold.tail%0d", k));
        step(done_v(), "hold.done");

        // Reset after pixel 7: frame abandoned with no frame_done.
        for (int i = 0; i < 7; i++)
            step(pix_v(i, VB'(i + 1), i == 0), $sformatf("rst.pix%0d", i));
        up_if.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++)
            step(gap_v(), $sformatf("rst.idle%0d", k));
        run_frame("rst.frame");

        // SOF asserted on pixel 5 of a streaming frame.
        for (int i = 0; i < 4; i++)
            step(pix_v(i, VB'(i + 1), i == 0), $sformatf("sof5.pix%0d", i));
`ifdef SOF_RESYNC_EN
        step(pix_v(0, VB'(5), 1'b1), "sof5.restart");
        for (int j = 1; j < N_PIX; j++)
            step(pix_v(j, VB'(5 + j), 1'b0), $sformatf("sof5.new%0d", j));
`else
        for (int i = 4; i < N_PIX; i++)
            step(pix_v(i, VB'(i + 1), i == 4), $sformatf("sof5.pix%0d", i));
`endif
        for (int k = 0; k < N_DRAIN; k++)
            step(drain_v(1'b0, 1'b0, '0), $sformatf("sof5.drain%0d", k));
        step(done_v(), "sof5.done");
        step(gap_v(), "sof5.quiet");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_streamer.md
# frame_streamer

Source side of the spatial filtering pipeline: accepts raw pixels from an upstream valid/ready source and emits the `en`-qualified pixel stream the smoothing/kernel pipeline consumes. It also marks frame/line positions and, after the last pixel of a frame, drains the pipeline by injecting zero pixels. It raises `out_valid` on the beats whose downstream smoothed result corresponds to a real, centred pixel.

## Interface
- `FRAME_WIDTH`, 1024, pixels per line
- `FRAME_HEIGHT`, 768, lines per frame
- `VALUE_BITS`, 9, pixel width
- `KERNEL_WIDTH`, 3, downstream window width (odd)
- `KERNEL_HEIGHT`, 3, downstream window height (odd)
- `PIPE_STAGES`, 3, `en`-beats of downstream kernel/register latency
- `DRAIN_BEATS` (derived, local), `FRAME_WIDTH*(KERNEL_HEIGHT/2) + KERNEL_WIDTH/2 + PIPE_STAGES`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  upstream pixel valid
- `s_ready`  out  1  upstream pixel accepted when `s_valid & s_ready`
- `s_data`  in  `VALUE_BITS`  upstream pixel
- `s_sof`  in  1  upstream start-of-frame marker, qualified by `s_valid`
- `en`  out  1  one-beat advance strobe to the pipeline
- `value_out`  out  `VALUE_BITS`  pixel to the pipeline, meaningful when `en`=1
- `sof_out`  out  1  with `en`: beat 0 of frame
- `eol_out`  out  1  with `en`: last pixel of a line (drain beats: 0)
- `out_valid`  out  1  with `en`: the downstream result produced by this beat is a real pixel
- `frame_done`  out  1  one-cycle pulse when the drain completes

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: `s_ready`=1. Beats without `s_sof` are discarded (no `en`). An accepted beat with `s_sof`=1 is pixel (0,0); the block emits it and moves to STREAM with x=1, y=0.
- STREAM: `s_ready`=1. Each accepted beat is emitted. x increments; at x=`FRAME_WIDTH`-1, x wraps to 0 and y increments. Acceptance of (W-1,H-1) → DRAIN with drain count = `DRAIN_BEATS`-1.
- DRAIN: `s_ready`=0. `en`=1 every cycle with `value_out`=0, `eol_out`=0. When the count reaches 0: → IDLE, and `frame_done` pulses on the following cycle.
- Beat counter b counts `en` beats from 0 at SOF and covers `FRAME_WIDTH*FRAME_HEIGHT+DRAIN_BEATS` beats; width is clog2 of that value. `out_valid` = (b ≥ `DRAIN_BEATS`). Exactly W·H beats per frame carry `out_valid`=1.
- `s_ready` is combinational from state only, never from `s_valid`.

## Timing
- Reset: state IDLE; counters 0; `en`, `value_out`, `sof_out`, `eol_out`, `out_valid`, `frame_done` = 0. `s_ready`=0 while `rst_n`=0.
- `en`/`value_out`/flags are registered: they appear 1 cycle after the accepting edge.
- No `en` bubbles in DRAIN. In STREAM, `en` mirrors upstream gaps.
- The last STREAM beat and the first DRAIN beat are consecutive cycles.
- Reset mid-frame: the frame is abandoned immediately. No `frame_done` is produced, and the next frame requires `s_sof`.
- `s_sof`=1 received during DRAIN: not accepted (`s_ready`=0). Upstream holds it until IDLE.

## Configuration
- `SOF_RESYNC_EN` defined: in STREAM, an accepted beat with `s_sof`=1 restarts the frame. It is emitted as pixel (0,0) with `sof_out`=1, and x, y and b all restart. No drain is inserted for the aborted frame.
- Not defined: `s_sof` is ignored in STREAM and the beat is treated as an ordinary pixel.

## Test plan
Settings for all cases: W=4, H=3, KW=KH=3, PIPE_STAGES=1, which gives DRAIN_BEATS=6.
- Reset, then continuous `s_valid` with `s_sof` on the first beat of pixels 1..12:
  - 18 `en` beats, values 1..12 then six 0s.
  - `sof_out` on beat 0; `eol_out` on beats 3, 7, 11.
  - `out_valid` on beats 6..17.
  - `frame_done` 1 cycle after beat 17.
- Same frame with `s_valid` toggling every other cycle: identical `en` value sequence, with `en` gaps matching the input gaps in STREAM only.
- Three non-SOF beats in IDLE, then an SOF frame: the three beats produce no `en`, and the frame output is as in case 1.
- `s_sof` held high on a beat during DRAIN: `s_ready`=0 until IDLE; the beat is accepted on the first IDLE cycle and starts a new frame.
- `rst_n` low at pixel 7: all outputs 0 immediately and no `frame_done`. A new SOF frame then behaves as in case 1.
- `s_sof` on pixel 5 of STREAM:
  - With `SOF_RESYNC_EN`: `sof_out` on that beat, followed by 12+6 beats.
  - Without it: the frame ends normally after 12 pixels.
